// File: rtl/nlin_f_vect_unit.sv
// Vector activation unit: identity / ReLU / leaky ReLU / clamp / hard-tanh applied per word.
// Two-stage valid/ready pipeline. Config is latched on the first beat of each tensor.
module nlin_f_vect_unit #(
  parameter int unsigned VECT_SIZE = 8,
  parameter int unsigned WORD_WDT  = 16,
  parameter int unsigned FRAC_WDT  = 8,
  parameter int unsigned TYPE_WDT  = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [2:0]                    cfg_mode,
  input  logic [3:0]                    cfg_leak_shift,
  input  logic [WORD_WDT-1:0]           cfg_clamp_lo,
  input  logic [WORD_WDT-1:0]           cfg_clamp_hi,
  input  logic                          in_vld,
  output logic                          in_rdy,
  input  logic [VECT_SIZE*WORD_WDT-1:0] in_data,
  input  logic                          in_last,
  input  logic [TYPE_WDT-1:0]           in_type,
  output logic                          out_vld,
  input  logic                          out_rdy,
  output logic [VECT_SIZE*WORD_WDT-1:0] out_data,
  output logic                          out_last,
  output logic [TYPE_WDT-1:0]           out_type,
  output logic                          busy,
  input  logic                          sat_clr,
  output logic [31:0]                   sat_cnt,
  output logic                          cfg_err
);

  localparam int unsigned DW = VECT_SIZE * WORD_WDT;

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ACTIVE = 1'b1;

  localparam logic [2:0] MODE_ID    = 3'd0;
  localparam logic [2:0] MODE_RELU  = 3'd1;
  localparam logic [2:0] MODE_LEAKY = 3'd2;
  localparam logic [2:0] MODE_CLAMP = 3'd3;
  localparam logic [2:0] MODE_HTANH = 3'd4;

  localparam logic [TYPE_WDT-1:0] TYPE_DATA = '0;

  // Hard-tanh bounds +/-1.0; they collapse to the word range when 1.0 is not representable.
  localparam logic signed [WORD_WDT-1:0] HT_HI = (WORD_WDT - 1 <= FRAC_WDT) ?
                                                 {1'b0, {(WORD_WDT-1){1'b1}}} :
                                                 WORD_WDT'((1 << FRAC_WDT) - 1);
  localparam logic signed [WORD_WDT-1:0] HT_LO = ~HT_HI;

  function automatic logic signed [WORD_WDT-1:0] f_clamp(
    input logic signed [WORD_WDT-1:0] x,
    input logic signed [WORD_WDT-1:0] lo,
    input logic signed [WORD_WDT-1:0] hi
  );
    logic signed [WORD_WDT-1:0] y;
    if (lo > hi)      y = lo;
    else if (x < lo)  y = lo;
    else if (x > hi)  y = hi;
    else              y = x;
    return y;
  endfunction

  function automatic logic signed [WORD_WDT-1:0] f_act(
    input logic [2:0]                 mode,
    input logic [3:0]                 sh,
    input logic signed [WORD_WDT-1:0] lo,
    input logic signed [WORD_WDT-1:0] hi,
    input logic signed [WORD_WDT-1:0] x
  );
    logic signed [WORD_WDT-1:0] y;
    case (mode)
      MODE_ID:    y = x;
      MODE_RELU:  y = x[WORD_WDT-1] ? '0 : x;
      MODE_LEAKY: y = x[WORD_WDT-1] ? (x >>> sh) : x;
      MODE_CLAMP: y = f_clamp(x, lo, hi);
      MODE_HTANH: y = f_clamp(x, HT_LO, HT_HI);
      default:    y = '0;
    endcase
    return y;
  endfunction

  logic [0:0]                 r_state;
  logic                       r_in_en;
  logic [2:0]                 r_mode;
  logic [3:0]                 r_shift;
  logic [WORD_WDT-1:0]        r_lo;
  logic [WORD_WDT-1:0]        r_hi;
  logic                       r_err;
  logic [31:0]                r_sat_cnt;
  logic                       r_s1_vld;
  logic [DW-1:0]              r_s1_data;
  logic                       r_s1_last;
  logic [TYPE_WDT-1:0]        r_s1_type;
  logic                       r_s2_vld;
  logic [DW-1:0]              r_s2_data;
  logic                       r_s2_last;
  logic [TYPE_WDT-1:0]        r_s2_type;

  logic                       w_idle;
  logic                       w_s2_load;
  logic                       w_s1_load;
  logic                       w_acc;
  logic                       w_is_data;
  logic [2:0]                 w_mode;
  logic [3:0]                 w_shift;
  logic signed [WORD_WDT-1:0] w_lo;
  logic signed [WORD_WDT-1:0] w_hi;
  logic [DW-1:0]              w_s1_data_n;
  logic [VECT_SIZE-1:0]       w_chg;
  logic [31:0]                w_inc;
  logic [31:0]                w_add;
  logic [32:0]                w_sum;

  assign w_idle    = (r_state == ST_IDLE);
  assign w_s2_load = ~r_s2_vld | out_rdy;
  assign w_s1_load = ~r_s1_vld | w_s2_load;
  assign in_rdy    = r_in_en & w_s1_load;
  assign w_acc     = in_vld & in_rdy;
  assign w_is_data = (in_type == TYPE_DATA);

  // The capturing beat itself must see the live config, later beats the shadow copy.
  assign w_mode  = w_idle ? cfg_mode       : r_mode;
  assign w_shift = w_idle ? cfg_leak_shift : r_shift;
  assign w_lo    = w_idle ? cfg_clamp_lo   : r_lo;
  assign w_hi    = w_idle ? cfg_clamp_hi   : r_hi;

  for (genvar g = 0; g < VECT_SIZE; g++) begin : g_word
    logic signed [WORD_WDT-1:0] w_x;
    logic signed [WORD_WDT-1:0] w_y;
    assign w_x = in_data[g*WORD_WDT +: WORD_WDT];
    assign w_y = f_act(w_mode, w_shift, w_lo, w_hi, w_x);
    assign w_s1_data_n[g*WORD_WDT +: WORD_WDT] = w_is_data ? w_y : w_x;
    assign w_chg[g] = (w_y != w_x);
  end

  always_comb begin
    w_inc = '0;
    for (int unsigned i = 0; i < VECT_SIZE; i++) begin
      w_inc = w_inc + 32'(w_chg[i]);
    end
  end

  assign w_add = (w_acc && w_is_data && (w_mode == MODE_CLAMP || w_mode == MODE_HTANH)) ?
                 w_inc : '0;
  assign w_sum = {1'b0, r_sat_cnt} + {1'b0, w_add};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_in_en   <= 1'b0;
      r_mode    <= '0;
      r_shift   <= '0;
      r_lo      <= '0;
      r_hi      <= '0;
      r_err     <= 1'b0;
      r_sat_cnt <= '0;
    end else begin
      r_in_en <= 1'b1;
      if (w_acc) begin
        if (w_idle) begin
          r_mode  <= cfg_mode;
          r_shift <= cfg_leak_shift;
          r_lo    <= cfg_clamp_lo;
          r_hi    <= cfg_clamp_hi;
          if (cfg_mode > MODE_HTANH) r_err <= 1'b1;
          if (!in_last) r_state <= ST_ACTIVE;
        end else if (in_last) begin
          r_state <= ST_IDLE;
        end
      end
      if (sat_clr)       r_sat_cnt <= w_add;
      else if (w_sum[32]) r_sat_cnt <= '1;
      else               r_sat_cnt <= w_sum[31:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_vld  <= 1'b0;
      r_s1_data <= '0;
      r_s1_last <= 1'b0;
      r_s1_type <= '0;
      r_s2_vld  <= 1'b0;
      r_s2_data <= '0;
      r_s2_last <= 1'b0;
      r_s2_type <= '0;
    end else begin
      if (w_s1_load) begin
        r_s1_vld <= w_acc;
        if (w_acc) begin
          r_s1_data <= w_s1_data_n;
          r_s1_last <= in_last;
          r_s1_type <= in_type;
        end
      end
      if (w_s2_load) begin
        r_s2_vld <= r_s1_vld;
        if (r_s1_vld) begin
          r_s2_data <= r_s1_data;
          r_s2_last <= r_s1_last;
          r_s2_type <= r_s1_type;
        end
      end
    end
  end

  assign out_vld  = r_s2_vld;
  assign out_data = r_s2_data;
  assign out_last = r_s2_last;
  assign out_type = r_s2_type;
  assign busy     = (r_state == ST_ACTIVE);
  assign sat_cnt  = r_sat_cnt;
  assign cfg_err  = r_err;

endmodule

// File: tb/tb_nlin_f_vect_unit.sv
// Self-checking bench for nlin_f_vect_unit: directed vector table, corner sequences,
// and randomized traffic scored against an arithmetic reference model.
`timescale 1ns/1ps
module tb_nlin_f_vect_unit;

  localparam int VS = 4;
  localparam int WW = 16;
  localparam int FW = 8;
  localparam int TW = 2;
  localparam int DW = VS * WW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [2:0]    cfg_mode;
  logic [3:0]    cfg_leak_shift;
  logic [WW-1:0] cfg_clamp_lo;
  logic [WW-1:0] cfg_clamp_hi;
  logic          in_vld;
  logic          in_rdy;
  logic [DW-1:0] in_data;
  logic          in_last;
  logic [TW-1:0] in_type;
  logic          out_vld;
  logic          out_rdy;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic [TW-1:0] out_type;
  logic          busy;
  logic          sat_clr;
  logic [31:0]   sat_cnt;
  logic          cfg_err;

  nlin_f_vect_unit #(.VECT_SIZE(VS), .WORD_WDT(WW), .FRAC_WDT(FW), .TYPE_WDT(TW)) dut (
    .clk(clk), .rst(rst),
    .cfg_mode(cfg_mode), .cfg_leak_shift(cfg_leak_shift),
    .cfg_clamp_lo(cfg_clamp_lo), .cfg_clamp_hi(cfg_clamp_hi),
    .in_vld(in_vld), .in_rdy(in_rdy), .in_data(in_data), .in_last(in_last), .in_type(in_type),
    .out_vld(out_vld), .out_rdy(out_rdy), .out_data(out_data), .out_last(out_last),
    .out_type(out_type), .busy(busy), .sat_clr(sat_clr), .sat_cnt(sat_cnt), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
    logic [TW-1:0] typ;
  } beat_t;

  typedef struct {
    logic [2:0]    mode;
    logic [3:0]    sh;
    logic [WW-1:0] lo;
    logic [WW-1:0] hi;
    logic [DW-1:0] din;
    logic [TW-1:0] typ;
    logic [DW-1:0] exp;
  } vec_t;

  int total = 0;
  int bad   = 0;

  beat_t exp_q[$];
  beat_t seen_q[$];
  beat_t prev_out;
  bit    prev_stall = 0;
  bit    last_acc   = 0;

  // reference model state
  bit              m_active = 0;
  bit              m_err    = 0;
  longint unsigned m_sat    = 0;
  int              m_mode, m_sh, m_lo, m_hi;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic int ref_word(input int mode, input int sh, input int lo, input int hi,
                                  input int x);
    int d;
    case (mode)
      0: return x;
      1: return (x < 0) ? 0 : x;
      2: begin
        d = 1 << sh;
        return (x < 0) ? (x - (d - 1)) / d : x;
      end
      3: return (lo > hi) ? lo : (x < lo) ? lo : (x > hi) ? hi : x;
      4: return (x < -(1 << FW)) ? -(1 << FW) : (x > (1 << FW) - 1) ? (1 << FW) - 1 : x;
      default: return 0;
    endcase
  endfunction

  task automatic model_accept(output int inc);
    beat_t b;
    logic signed [WW-1:0] t;
    int x, y;
    if (!m_active) begin
      m_mode = int'(cfg_mode);
      m_sh   = int'(cfg_leak_shift);
      t = cfg_clamp_lo; m_lo = t;
      t = cfg_clamp_hi; m_hi = t;
      if (m_mode > 4) m_err = 1;
    end
    inc = 0;
    b.data = '0;
    b.last = in_last;
    b.typ  = in_type;
    for (int i = 0; i < VS; i++) begin
      t = in_data[i*WW +: WW];
      x = t;
      y = (in_type != 0) ? x : ref_word(m_mode, m_sh, m_lo, m_hi, x);
      b.data[i*WW +: WW] = y[WW-1:0];
      if (in_type == 0 && (m_mode == 3 || m_mode == 4) && y != x) inc++;
    end
    exp_q.push_back(b);
    if (!m_active) m_active = !in_last;
    else if (in_last) m_active = 0;
  endtask

  // One clock: sample mid-cycle, score, advance to just after the next rising edge.
  task automatic step();
    int    inc;
    beat_t e;
    beat_t g;
    #4;
    chk("busy", busy, m_active);
    chk("cfg_err", cfg_err, m_err);
    chk("sat_cnt", sat_cnt, m_sat);
    if (prev_stall) begin
      chk("stall_vld", out_vld, 1'b1);
      chk("stall_data", out_data, prev_out.data);
      chk("stall_last", out_last, prev_out.last);
      chk("stall_type", out_type, prev_out.typ);
    end
    last_acc = in_vld && in_rdy;
    inc = 0;
    if (last_acc) model_accept(inc);
    if (sat_clr) m_sat = inc;
    else begin
      m_sat = m_sat + inc;
      if (m_sat > 64'hFFFF_FFFF) m_sat = 64'hFFFF_FFFF;
    end
    if (out_vld && out_rdy) begin
      g.data = out_data; g.last = out_last; g.typ = out_type;
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_out: got %h want no beat", out_data);
      end else begin
        e = exp_q.pop_front();
        chk("out_data", out_data, e.data);
        chk("out_last", out_last, e.last);
        chk("out_type", out_type, e.typ);
      end
      seen_q.push_back(g);
    end
    prev_stall    = out_vld && !out_rdy;
    prev_out.data = out_data;
    prev_out.last = out_last;
    prev_out.typ  = out_type;
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [DW-1:0] d, input logic l, input logic [TW-1:0] t);
    int n;
    n = 0;
    in_data = d; in_last = l; in_type = t; in_vld = 1'b1;
    do begin
      step();
      n++;
    end while (!last_acc && n < 20);
    in_vld = 1'b0;
    if (!last_acc) begin
      total++; bad++;
      $display("FAIL send_timeout: got no accept want accept");
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    in_vld = 1'b0; out_rdy = 1'b1;
    while ((exp_q.size() != 0 || out_vld) && n < 20) begin
      step();
      n++;
    end
    chk("drain_empty", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1; in_vld = 1'b0; sat_clr = 1'b0; in_last = 1'b0; in_type = '0; in_data = '0;
    exp_q.delete();
    m_active = 0; m_err = 0; m_sat = 0; prev_stall = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_rdy", in_rdy, 0);
    chk("rst_out_vld", out_vld, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sat_cnt", sat_cnt, 0);
    chk("rst_cfg_err", cfg_err, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_out_type", out_type, 0);
    #3 rst = 1'b0;
    #1 chk("rdy_before_edge", in_rdy, 0);
    @(posedge clk);
    #1;
    chk("rdy_after_edge", in_rdy, 1);
  endtask

  function automatic logic [WW-1:0] rand_word();
    case ($urandom_range(0, 5))
      0:       return 16'h8000;
      1:       return 16'h7FFF;
      2:       return 16'hFFFF;
      3:       return WW'($urandom_range(0, 600)) - 16'd300;
      default: return WW'($urandom);
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    vec_t          tbl[10];
    logic [DW-1:0] bd[6];
    logic [DW-1:0] w36, e36;
    int            lat, k, n;

    tbl[0] = '{3'd1, 4'd0,  16'h0000, 16'h0000, 64'h8000_0000_FF00_0100, 2'd0, 64'h0000_0000_0000_0100};
    tbl[1] = '{3'd2, 4'd2,  16'h0000, 16'h0000, 64'hFFFF_8000_0010_FFF0, 2'd0, 64'hFFFF_E000_0010_FFFC};
    tbl[2] = '{3'd3, 4'd0,  16'hFF80, 16'h0040, 64'h7FFF_8000_0010_FFC0, 2'd0, 64'h0040_FF80_0010_FFC0};
    tbl[3] = '{3'd3, 4'd0,  16'h0010, 16'hFFF0, 64'h0004_0003_0002_0001, 2'd0, 64'h0010_0010_0010_0010};
    tbl[4] = '{3'd0, 4'd5,  16'h0000, 16'h0000, 64'h8000_7FFF_1234_FFFF, 2'd0, 64'h8000_7FFF_1234_FFFF};
    tbl[5] = '{3'd1, 4'd0,  16'h0000, 16'h0000, 64'h8000_FFFF_0001_F000, 2'd1, 64'h8000_FFFF_0001_F000};
    tbl[6] = '{3'd4, 4'd0,  16'h0000, 16'h0000, 64'h7FFF_0080_FE00_0200, 2'd0, 64'h00FF_0080_FF00_00FF};
    tbl[7] = '{3'd2, 4'd0,  16'h0000, 16'h0000, 64'h8000_FFFF_0001_FF00, 2'd0, 64'h8000_FFFF_0001_FF00};
    tbl[8] = '{3'd2, 4'd15, 16'h0000, 16'h0000, 64'h8000_FFFF_0100_C000, 2'd0, 64'hFFFF_FFFF_0100_FFFF};
    tbl[9] = '{3'd4, 4'd0,  16'h0000, 16'h0000, 64'hFF00_00FF_FEFF_0100, 2'd0, 64'hFF00_00FF_FF00_00FF};

    cfg_mode = '0; cfg_leak_shift = '0; cfg_clamp_lo = '0; cfg_clamp_hi = '0;
    in_vld = 1'b0; in_data = '0; in_last = 1'b0; in_type = '0; out_rdy = 1'b1; sat_clr = 1'b0;
    do_reset();

    // directed single-beat vectors
    for (int i = 0; i < 10; i++) begin
      cfg_mode = tbl[i].mode; cfg_leak_shift = tbl[i].sh;
      cfg_clamp_lo = tbl[i].lo; cfg_clamp_hi = tbl[i].hi;
      out_rdy = 1'b1;
      seen_q.delete();
      send_beat(tbl[i].din, 1'b1, tbl[i].typ);
      lat = 0;
      while (seen_q.size() == 0 && lat < 8) begin
        step();
        lat++;
      end
      chk($sformatf("tbl%0d_latency", i), lat, 2);
      if (seen_q.size() != 0) begin
        chk($sformatf("tbl%0d_data", i), seen_q[0].data, tbl[i].exp);
        chk($sformatf("tbl%0d_last", i), seen_q[0].last, 1'b1);
        chk($sformatf("tbl%0d_type", i), seen_q[0].typ, tbl[i].typ);
      end
    end
    drain();

    // saturation counter: count, clear-with-increment, plain clear
    sat_clr = 1'b1; step(); sat_clr = 1'b0;
    cfg_mode = 3'd4;
    send_beat(64'h7FFF_0080_FE00_0200, 1'b1, 2'd0);
    chk("sat_cnt_htanh", sat_cnt, 3);
    sat_clr = 1'b1;
    send_beat(64'h7FFF_0080_FE00_0200, 1'b1, 2'd0);
    sat_clr = 1'b0;
    chk("sat_clr_with_inc", sat_cnt, 3);
    sat_clr = 1'b1; step(); sat_clr = 1'b0;
    chk("sat_clr", sat_cnt, 0);
    drain();

    // three-beat tensor: config changes after beat 1 are ignored
    w36 = 64'h0100_0080_FF00_0200;
    e36 = 64'h0100_0080_0000_0100;
    cfg_mode = 3'd3; cfg_clamp_lo = 16'h0000; cfg_clamp_hi = 16'h0100;
    seen_q.delete();
    chk("t36_busy_pre", busy, 0);
    send_beat(w36, 1'b0, 2'd0);
    cfg_mode = 3'd0; cfg_clamp_hi = 16'h7FFF;
    chk("t36_busy_b1", busy, 1);
    send_beat(w36, 1'b0, 2'd0);
    chk("t36_busy_b2", busy, 1);
    send_beat(w36, 1'b1, 2'd0);
    chk("t36_busy_b3", busy, 0);
    drain();
    chk("t36_count", seen_q.size(), 3);
    for (int i = 0; i < 3 && i < seen_q.size(); i++) begin
      chk($sformatf("t36_data%0d", i), seen_q[i].data, e36);
      chk($sformatf("t36_last%0d", i), seen_q[i].last, (i == 2));
    end

    // backpressure: two beats buffered, output held stable, no loss after release
    cfg_mode = 3'd0;
    for (int j = 0; j < 6; j++) bd[j] = {4{WW'(256 + j)}};
    seen_q.delete();
    out_rdy = 1'b0; in_last = 1'b1; in_type = '0; k = 0;
    for (int i = 0; i < 5; i++) begin
      in_data = bd[k]; in_vld = 1'b1;
      step();
      if (last_acc) k++;
      if (i >= 1) begin
        chk("bp_in_rdy", in_rdy, 0);
        chk("bp_out_vld", out_vld, 1);
        chk("bp_out_data", out_data, bd[0]);
      end
    end
    chk("bp_accepted", k, 2);
    out_rdy = 1'b1; n = 0;
    while (k < 6 && n < 30) begin
      in_data = bd[k]; in_vld = 1'b1;
      step();
      if (last_acc) k++;
      n++;
    end
    in_vld = 1'b0;
    drain();
    chk("bp_count", seen_q.size(), 6);
    for (int i = 0; i < 6 && i < seen_q.size(); i++)
      chk($sformatf("bp_order%0d", i), seen_q[i].data, bd[i]);

    // randomized traffic against the reference model
    for (int c = 0; c < 400; c++) begin
      in_vld  = ($urandom_range(0, 3) != 0);
      out_rdy = ($urandom_range(0, 9) < 7);
      in_last = ($urandom_range(0, 2) == 0);
      in_type = ($urandom_range(0, 5) == 0) ? TW'($urandom_range(1, 3)) : '0;
      cfg_mode = 3'($urandom_range(0, 4));
      cfg_leak_shift = 4'($urandom);
      if ($urandom_range(0, 7) == 0) begin
        cfg_clamp_lo = rand_word(); cfg_clamp_hi = rand_word();
      end else begin
        cfg_clamp_lo = WW'(0) - WW'($urandom_range(0, 700));
        cfg_clamp_hi = WW'($urandom_range(0, 700));
      end
      sat_clr = ($urandom_range(0, 31) == 0);
      for (int i = 0; i < VS; i++) in_data[i*WW +: WW] = rand_word();
      step();
    end
    sat_clr = 1'b0; out_rdy = 1'b1; cfg_mode = 3'd0;
    send_beat({4{16'h0001}}, 1'b1, 2'd0);
    drain();
    chk("rand_idle", busy, 0);

    // illegal mode, sticky error, then reset mid-tensor
    cfg_mode = 3'd6;
    seen_q.delete();
    send_beat(64'h1234_5678_9ABC_DEF0, 1'b1, 2'd0);
    cfg_mode = 3'd0;
    drain();
    chk("ill_count", seen_q.size(), 1);
    if (seen_q.size() != 0) chk("ill_zero", seen_q[0].data, 0);
    chk("ill_err", cfg_err, 1);
    cfg_mode = 3'd1;
    send_beat(64'h8000_0001_FFFF_0100, 1'b1, 2'd0);
    drain();
    chk("ill_err_sticky", cfg_err, 1);
    cfg_mode = 3'd0; out_rdy = 1'b0;
    send_beat(64'h0001_0002_0003_0004, 1'b0, 2'd0);
    step();
    chk("mid_pre_vld", out_vld, 1);
    chk("mid_pre_busy", busy, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_vld", out_vld, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_rdy", in_rdy, 0);
    chk("mid_rst_err", cfg_err, 0);
    do_reset();
    out_rdy = 1'b1;
    repeat (5) step();
    chk("post_rst_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
